// File: rtl/conv_operand_loader.sv
// conv_operand_loader: gathers 16 serial 4-bit samples (8 signal, 8 kernel)
// and presents them as a stable parallel frame to the convolution stage.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   in_data, in_valid     serial sample input
//   in_ready              registered accept indication
//   abort                 drop the partially loaded frame
//   frame_ack             consumer has taken the presented frame
//   x0..x7, h0..h7        presented signal / kernel operands
//   frame_valid           x/h hold a complete frame
//   load_idx              index of next sample (0..15)
//   frame_cnt             completed frames, modulo 256
module conv_operand_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    input  logic       frame_ack,
    output logic [3:0] x0,
    output logic [3:0] x1,
    output logic [3:0] x2,
    output logic [3:0] x3,
    output logic [3:0] x4,
    output logic [3:0] x5,
    output logic [3:0] x6,
    output logic [3:0] x7,
    output logic [3:0] h0,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic [3:0] h3,
    output logic [3:0] h4,
    output logic [3:0] h5,
    output logic [3:0] h6,
    output logic [3:0] h7,
    output logic       frame_valid,
    output logic [3:0] load_idx,
    output logic [7:0] frame_cnt
);

    typedef enum logic {LOAD, HOLD} state_t;

    state_t     state;
    state_t     state_nx;
    logic       xfer;
    logic       last;
    logic [3:0] stage [16];
    logic [3:0] xr    [8];
    logic [3:0] hr    [8];

    always_comb begin
        state_nx = state;
        xfer     = 1'b0;
        last     = 1'b0;
        unique case (state)
            LOAD: begin
                xfer = in_valid && in_ready && !abort;
                last = xfer && (load_idx == 4'd15);
                if (last)
                    state_nx = HOLD;
            end
            HOLD: begin
                if (frame_ack)
                    state_nx = LOAD;
            end
        endcase
    end

    // in_ready is registered: it follows the next state, so it stays low
    // for the first edge after reset and drops on the completing edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOAD;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_idx  <= 4'd0;
            frame_cnt <= 8'd0;
            for (int i = 0; i < 16; i++)
                stage[i] <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                xr[i] <= 4'd0;
                hr[i] <= 4'd0;
            end
        end else if (state == LOAD && abort) begin
            load_idx <= 4'd0;
        end else if (xfer) begin
            stage[load_idx] <= in_data;
            // 4-bit wrap returns the index to 0 on the last sample
            load_idx <= load_idx + 4'd1;
            if (last) begin
                for (int i = 0; i < 8; i++)
                    xr[i] <= stage[i];
                for (int i = 0; i < 7; i++)
                    hr[i] <= stage[i+8];
                // final sample bypasses staging into h7
                hr[7]     <= in_data;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign frame_valid = (state == HOLD);

    assign x0 = xr[0];
    assign x1 = xr[1];
    assign x2 = xr[2];
    assign x3 = xr[3];
    assign x4 = xr[4];
    assign x5 = xr[5];
    assign x6 = xr[6];
    assign x7 = xr[7];
    assign h0 = hr[0];
    assign h1 = hr[1];
    assign h2 = hr[2];
    assign h3 = hr[3];
    assign h4 = hr[4];
    assign h5 = hr[5];
    assign h6 = hr[6];
    assign h7 = hr[7];

endmodule

// File: tb/tb_conv_operand_loader.sv
// tb_conv_operand_loader: directed stimulus with a frame-level reference
// model compared against the loader every cycle, plus literal checks.
module tb_conv_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic       frame_ack;
    logic [3:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic [3:0] h0, h1, h2, h3, h4, h5, h6, h7;
    logic       frame_valid;
    logic [3:0] load_idx;
    logic [7:0] frame_cnt;

    int n_pass = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    conv_operand_loader dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .frame_ack(frame_ack),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3),
        .h4(h4), .h5(h5), .h6(h6), .h7(h7),
        .frame_valid(frame_valid), .load_idx(load_idx),
        .frame_cnt(frame_cnt)
    );

    // Reference model: a list of accepted samples and the last full frame.
    int  m_samp [16];
    int  m_x [8];
    int  m_h [8];
    int  m_idx;
    int  m_cnt;
    bit  m_hold;
    bit  m_first;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hold  = 1'b0;
            m_first = 1'b1;
            m_idx   = 0;
            m_cnt   = 0;
            for (int i = 0; i < 8; i++) begin
                m_x[i] = 0;
                m_h[i] = 0;
            end
        end else if (m_first) begin
            m_first = 1'b0;
        end else if (!m_hold) begin
            if (abort) begin
                m_idx = 0;
            end else if (in_valid) begin
                m_samp[m_idx] = int'(in_data);
                m_idx = m_idx + 1;
                if (m_idx == 16) begin
                    for (int i = 0; i < 8; i++) begin
                        m_x[i] = m_samp[i];
                        m_h[i] = m_samp[i+8];
                    end
                    m_idx  = 0;
                    m_cnt  = (m_cnt + 1) % 256;
                    m_hold = 1'b1;
                end
            end
        end else if (frame_ack) begin
            m_hold = 1'b0;
        end
    end

    function automatic void chk(string nm, logic [127:0] act,
                                logic [127:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    logic [77:0] dut_vec;
    logic [77:0] mdl_vec;

    always @(negedge clk) begin
        if (check_en) begin
            dut_vec = {in_ready, frame_valid, load_idx, frame_cnt,
                       x0, x1, x2, x3, x4, x5, x6, x7,
                       h0, h1, h2, h3, h4, h5, h6, h7};
            mdl_vec = {!m_first && !m_hold, m_hold, 4'(m_idx), 8'(m_cnt),
                       4'(m_x[0]), 4'(m_x[1]), 4'(m_x[2]), 4'(m_x[3]),
                       4'(m_x[4]), 4'(m_x[5]), 4'(m_x[6]), 4'(m_x[7]),
                       4'(m_h[0]), 4'(m_h[1]), 4'(m_h[2]), 4'(m_h[3]),
                       4'(m_h[4]), 4'(m_h[5]), 4'(m_h[6]), 4'(m_h[7])};
            chk("cycle_model", 128'(dut_vec), 128'(mdl_vec));
        end
    end

    task automatic cyc(input logic v, input logic [3:0] d,
                       input logic a, input logic k);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        abort     = a;
        frame_ack = k;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        abort     = 1'b0;
        frame_ack = 1'b0;

        // Reset state
        idle();
        check_en = 1'b1;
        idle();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_frame_valid", 128'(frame_valid), 128'(0));
        chk("rst_load_idx", 128'(load_idx), 128'(0));
        chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
        chk("rst_x0", 128'(x0), 128'(0));
        rst_n = 1'b1;
        idle();
        chk("release_in_ready", 128'(in_ready), 128'(1));
        chk("release_load_idx", 128'(load_idx), 128'(0));

        // Stream 1..8 then 8..1
        for (int k = 0; k < 16; k++)
            cyc(1'b1, (k < 8) ? 4'(k + 1) : 4'(16 - k), 1'b0, 1'b0);
        idle();
        chk("s1_frame_valid", 128'(frame_valid), 128'(1));
        chk("s1_in_ready", 128'(in_ready), 128'(0));
        chk("s1_x0", 128'(x0), 128'(1));
        chk("s1_x7", 128'(x7), 128'(8));
        chk("s1_h0", 128'(h0), 128'(8));
        chk("s1_h7", 128'(h7), 128'(1));
        chk("s1_frame_cnt", 128'(frame_cnt), 128'(1));

        // Hold with in_valid active, then acknowledge
        repeat (5) cyc(1'b1, 4'hF, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("hold_x3", 128'(x3), 128'(4));
        chk("hold_h5", 128'(h5), 128'(3));
        chk("hold_load_idx", 128'(load_idx), 128'(0));
        idle();
        chk("ack_frame_valid", 128'(frame_valid), 128'(0));
        chk("ack_in_ready", 128'(in_ready), 128'(1));
        chk("ack_load_idx", 128'(load_idx), 128'(0));
        chk("ack_x0_kept", 128'(x0), 128'(1));

        // Abort after 5 samples, then reload with 0x3
        repeat (5) cyc(1'b1, 4'h9, 1'b0, 1'b0);
        cyc(1'b1, 4'h7, 1'b1, 1'b0);
        chk("pre_abort_idx", 128'(load_idx), 128'(5));
        idle();
        chk("abort_idx", 128'(load_idx), 128'(0));
        chk("abort_x0_kept", 128'(x0), 128'(1));
        chk("abort_cnt_kept", 128'(frame_cnt), 128'(1));
        repeat (16) cyc(1'b1, 4'h3, 1'b0, 1'b0);
        idle();
        chk("reload_frame", 128'({x0, x1, x2, x3, x4, x5, x6, x7,
                                  h0, h1, h2, h3, h4, h5, h6, h7}),
            128'(64'h3333_3333_3333_3333));
        chk("reload_cnt", 128'(frame_cnt), 128'(2));
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        // Samples 0..15 with random gaps
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 2)) idle();
            cyc(1'b1, 4'(k), 1'b0, 1'b0);
            if (k == 10)
                chk("gap_stable_x0", 128'(x0), 128'(3));
        end
        idle();
        chk("gap_x", 128'({x0, x1, x2, x3, x4, x5, x6, x7}),
            128'(32'h0123_4567));
        chk("gap_h", 128'({h0, h1, h2, h3, h4, h5, h6, h7}),
            128'(32'h89AB_CDEF));
        chk("gap_cnt", 128'(frame_cnt), 128'(3));
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        // Reset at load_idx 9
        for (int k = 0; k < 9; k++)
            cyc(1'b1, 4'(k + 1), 1'b0, 1'b0);
        idle();
        chk("mid_idx", 128'(load_idx), 128'(9));
        rst_n = 1'b0;
        idle();
        chk("midrst_all", 128'({in_ready, frame_valid, load_idx, frame_cnt,
                                x0, x7, h0, h7}), 128'(0));
        rst_n = 1'b1;
        idle();
        chk("midrst_ready", 128'(in_ready), 128'(1));

        // Reset in HOLD
        repeat (16) cyc(1'b1, 4'hA, 1'b0, 1'b0);
        idle();
        chk("hold2_valid", 128'(frame_valid), 128'(1));
        rst_n = 1'b0;
        idle();
        chk("holdrst_all", 128'({in_ready, frame_valid, load_idx, frame_cnt,
                                 x0, x7, h0, h7}), 128'(0));
        rst_n = 1'b1;
        idle();
        chk("holdrst_ready", 128'(in_ready), 128'(1));

        // 256 frames wrap frame_cnt
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 16; k++)
                cyc(1'b1, 4'(f + k), 1'b0, 1'b0);
            cyc(1'b0, 4'h0, 1'b0, 1'b1);
            if (f == 254)
                chk("cnt_255", 128'(frame_cnt), 128'(255));
        end
        idle();
        chk("cnt_wrap", 128'(frame_cnt), 128'(0));
        chk("wrap_ready", 128'(in_ready), 128'(1));

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_operand_loader.md
CONV_OPERAND_LOADER -- requirements
Module: conv_operand_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset, both listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_data  input  4  serial operand sample.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  loader accepts a sample this cycle; registered.
REQ-007 abort  input  1  discard the partially loaded frame.
REQ-008 frame_ack  input  1  consumer has taken the presented frame.
REQ-009 x0..x7  output  4 each  presented signal operands for the convolution stage.
REQ-010 h0..h7  output  4 each  presented kernel operands for the convolution stage.
REQ-011 frame_valid  output  1  x0..x7 and h0..h7 hold a complete, stable frame.
REQ-012 load_idx  output  4  index of the next sample to be accepted (0..15).
REQ-013 frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-014 Transfer SHALL occur only on a rising clk where in_valid=1, in_ready=1, abort=0 and rst_n=1.
REQ-015 States SHALL be exactly LOAD (in_ready=1, frame_valid=0) and HOLD (in_ready=0, frame_valid=1).
REQ-016 Transfer order SHALL be fixed:
- sample k (k=0..7) writes staging x[k];
- sample k (k=8..15) writes staging h[k-8].
REQ-017 Each transfer SHALL increment load_idx by 1.
REQ-018 On the transfer with load_idx=15, the same edge SHALL:
- copy all 16 staged values (including this sample) to x0..x7/h0..h7;
- set frame_valid=1 and in_ready=0;
- reset load_idx to 0;
- increment frame_cnt;
- enter HOLD.
Latency from last sample to frame_valid is one edge.
REQ-019 x0..x7/h0..h7 SHALL change only on the edge that completes a frame. They SHALL stay stable during loading and during HOLD.
REQ-020 In HOLD, frame_ack=1 SHALL on that edge clear frame_valid, set in_ready=1 and enter LOAD. x/h outputs SHALL retain their values.
REQ-021 frame_ack SHALL be ignored in LOAD.
REQ-022 in_valid SHALL be ignored in HOLD; no staging write occurs.
REQ-023 abort=1 in LOAD SHALL reset load_idx to 0 with no staging write, even if in_valid=1 (abort wins). Staging contents become don't-care. Outputs, frame_cnt and frame_valid are unchanged.
REQ-024 abort=1 in HOLD SHALL have no effect.
REQ-025 frame_cnt SHALL wrap from 255 to 0.
REQ-026 Gaps in in_valid SHALL neither stall state nor lose samples.

Reset
REQ-027 rst_n=0 on a rising edge SHALL, regardless of state, set:
- state=LOAD, in_ready=0, frame_valid=0;
- load_idx=0, frame_cnt=0;
- all x/h outputs and staging registers to 0.
REQ-028 The first rising edge with rst_n=1 SHALL set in_ready=1. No transfer occurs on that edge.
REQ-029 Reset mid-load or in HOLD SHALL discard the partial or presented frame.

Verification
REQ-030 The bench SHALL cover:
- Stream 1,2,..,8 then 8,7,..,1, continuous valid -> one edge after 16th sample: frame_valid=1, x0=1..x7=8, h0=8..h7=1, frame_cnt=1, in_ready=0.
- Hold frame, drive in_valid=1 with data 0xF for 5 cycles, then frame_ack -> outputs unchanged; next edge frame_valid=0, in_ready=1, load_idx=0.
- Load 5 samples, abort together with in_valid=1, then reload 16 samples of 0x3 -> load_idx 5->0; final frame all 0x3; frame_cnt increments once.
- Random in_valid gaps across 16 samples 0..15 -> x0..x7=0..7, h0..h7=8..15; outputs stable until the completing edge.
- rst_n=0 at load_idx=9, and separately in HOLD -> all outputs 0, in_ready=1 one edge after release.
- 256 complete frames -> frame_cnt returns to 0.
